chip_cfg_rx: RTL

//  Chip-side receiver for the serial programming link driven by the FPGA (sclk/sdin, sclk idles high).

---
 rtl/chip_cfg_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/chip_cfg_rx.sv
// Chip-side serial programming receiver: oversamples sclk/sdin, shifts in one frame MSB-first, commits amplifier gain.
// Optional header validation enabled by defining CFG_RX_HDRCHK_EN.
module chip_cfg_rx #(
    parameter int unsigned NBITS    = 5,
    parameter int unsigned NHDR     = 2,
    parameter int unsigned TIMEOUT  = 128,
    parameter logic [2:0]  GAIN_RST = 3'd0
) (
    input  logic       i_mainclk,
    input  logic       i_resetAll,
    input  logic       i_sclk,
    input  logic       i_sdin,
    output logic [2:0] o_gainA1,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W  = $clog2(NBITS + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAIN_W = 3;

    typedef enum logic [1:0] {
        sIDLE  = 2'd0,
        sSHIFT = 2'd1,
        sCHECK = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [NBITS-1:0]  shreg, shreg_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [IDLE_W-1:0] idle, idle_nxt;
    logic [GAIN_W-1:0] gain_nxt;
    logic              ready_nxt;
    logic              busy_nxt;
    logic              err_nxt;

    logic sclk_s1, sclk_s2, sclk_d;
    logic sdin_s1, sdin_s2;
    logic rise_c;
    logic hdr_ok_c;

    // Two-flop synchronisers plus one delay stage for sclk edge detection
    always_ff @(posedge i_mainclk) begin
        if (i_resetAll) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
            sdin_s1 <= 1'b1;
            sdin_s2 <= 1'b1;
        end else begin
            sclk_s1 <= i_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            sdin_s1 <= i_sdin;
            sdin_s2 <= sdin_s1;
        end
    end

    assign rise_c = sclk_s2 & ~sclk_d;

`ifdef CFG_RX_HDRCHK_EN
    assign hdr_ok_c = (shreg[NBITS-1 -: NHDR] == '0);
`else
    logic unused_hdr;
    assign hdr_ok_c   = 1'b1;
    assign unused_hdr = ^shreg[NBITS-1 -: NHDR];
`endif

    always_ff @(posedge i_mainclk) begin
        if (i_resetAll) begin
            state       <= sIDLE;
            shreg       <= '0;
            count       <= '0;
            idle        <= '0;
            o_gainA1    <= GAIN_RST;
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            count       <= count_nxt;
            idle        <= idle_nxt;
            o_gainA1    <= gain_nxt;
            o_ready     <= ready_nxt;
            o_busy      <= busy_nxt;
            o_frame_err <= err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        count_nxt = count;
        idle_nxt  = idle;
        gain_nxt  = o_gainA1;
        ready_nxt = o_ready;
        busy_nxt  = o_busy;
        err_nxt   = 1'b0;

        case (state)
            sIDLE: begin
                idle_nxt = '0;
                if (rise_c) begin
                    shreg_nxt = {shreg[NBITS-2:0], sdin_s2};
                    count_nxt = CNT_W'(1);
                    busy_nxt  = 1'b1;
                    state_nxt = sSHIFT;
                end
            end

            sSHIFT: begin
                if (rise_c) begin
                    shreg_nxt = {shreg[NBITS-2:0], sdin_s2};
                    idle_nxt  = '0;
                    count_nxt = (count >= CNT_W'(NBITS)) ? count : count + CNT_W'(1);
                    if (count >= CNT_W'(NBITS - 1)) begin
                        state_nxt = sCHECK;
                    end
                end else if (idle >= IDLE_W'(TIMEOUT - 1)) begin
                    // sclk stalled mid-frame: drop the partial frame
                    idle_nxt  = IDLE_W'(TIMEOUT);
                    err_nxt   = 1'b1;
                    count_nxt = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = sIDLE;
                end else begin
                    idle_nxt = idle + IDLE_W'(1);
                end
            end

            sCHECK: begin
                if (hdr_ok_c) begin
                    gain_nxt  = shreg[GAIN_W-1:0];
                    ready_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
                count_nxt = '0;
                busy_nxt  = 1'b0;
                state_nxt = sIDLE;
            end

            default: begin
                count_nxt = '0;
                busy_nxt  = 1'b0;
                state_nxt = sIDLE;
            end
        endcase
    end

endmodule
